// File: rtl/peripheral_spram_wb_slave.sv
// Wishbone B3 slave front-end for a single-port RAM core: classic cycles plus
// CTI/BTE incrementing bursts sustained at one acknowledge per clock.
`timescale 1ns/1ps
module peripheral_spram_wb_slave #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [3:0]    ram_we,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        CLASSIC,
        BURST
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    state_t        state;
    state_t        state_next;
    logic          ack_next;
    logic          err_next;
    logic          req;
    logic [AW-1:0] word_adr;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] burst_adr;
    logic          unused_adr;

    assign req       = wb_cyc_i & wb_stb_i;
    assign word_adr  = wb_adr_i[AW+1:2];
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    // Bits that advance in a burst; the rest of the word address is held.
    always_comb begin
        case (wb_bte_i)
            2'b01:   wrap_mask = AW'(4'h3);
            2'b10:   wrap_mask = AW'(4'h7);
            2'b11:   wrap_mask = AW'(4'hF);
            default: wrap_mask = '1;
        endcase
    end

    assign burst_adr = (word_adr & ~wrap_mask) | ((word_adr + AW'(1)) & wrap_mask);

    // Inside a burst the RAM is read one beat ahead so data meets the next ack.
    assign ram_raddr = (state == BURST) ? burst_adr : word_adr;
    assign ram_waddr = word_adr;
    assign ram_din   = wb_dat_i;
    assign ram_we    = wb_sel_i & {4{wb_we_i & req & wb_ack_o}};
    assign wb_dat_o  = ram_dout;

    // NOTE: flops use non-blocking assignments so every register samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            state    <= state_next;
            wb_ack_o <= ack_next;
            wb_err_o <= err_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (wb_cti_i == CTI_INCR) begin
                        state_next = BURST;
                        ack_next   = 1'b1;
                    end else if (wb_cti_i == CTI_CLASSIC || wb_cti_i == CTI_END) begin
                        state_next = CLASSIC;
                        ack_next   = 1'b1;
                    end else begin
                        state_next = CLASSIC;
                        err_next   = 1'b1;
                    end
                end
            end
            CLASSIC: begin
                state_next = IDLE;
            end
            BURST: begin
                if (req && wb_cti_i == CTI_INCR) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_peripheral_spram_wb_slave.sv
// Self-checking bench for peripheral_spram_wb_slave: a Wishbone master driver,
// a RAM core model on the ram_* port, and a queue-based response scoreboard.
`timescale 1ns/1ps
module tb_peripheral_spram_wb_slave;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 32;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   adr = '0;
    logic [DW-1:0] dat_w = '0;
    logic [3:0]    sel = '0;
    logic          we = 1'b0;
    logic [2:0]    cti = '0;
    logic [1:0]    bte = '0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;
    logic [3:0]    ram_we;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout = '0;

    logic [31:0] ram [DEPTH];
    bit          written [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_pulses = 0;

    always #5 clk = ~clk;

    peripheral_spram_wb_slave #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr),
        .ram_dout (ram_dout)
    );

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_word(input int a);
        return written[a] ? ram[a] : init_word(a);
    endfunction

    // Burst address sequence: linear counts through the RAM, wrapN cycles in an N-word block.
    function automatic int next_word(input int w, input logic [1:0] b);
        int len;
        case (b)
            2'b01:   len = 4;
            2'b10:   len = 8;
            2'b11:   len = 16;
            default: len = DEPTH;
        endcase
        return (w - w % len) + (w + 1) % len;
    endfunction

    // RAM core: byte-lane writes, registered read one clock after ram_raddr.
    always @(posedge clk) begin
        if (|ram_we) begin
            ram[ram_waddr]     <= merge(ram_word(int'(ram_waddr)), ram_din, ram_we);
            written[ram_waddr] <= 1'b1;
        end
        ram_dout <= ram_word(int'(ram_raddr));
    end

    always @(negedge clk) begin
        if (|ram_we) we_pulses <= we_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every response the master would see pops one expectation.
    always @(negedge clk) begin
        if (!rst && cyc && stb && (ack || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", {ack, err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_ack", 32'(ack), 32'(!mon_e.err));
                check("resp_err", 32'(err), 32'(mon_e.err));
                if (mon_e.rd && !mon_e.err) check("read_data", dat_r, mon_e.data);
            end
        end
    end

    task automatic wait_ack(output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack || err) begin
                lat = i;
                rd  = dat_r;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic e_err, input logic e_rd, input logic [31:0] e_data);
        exp_t e;
        e.err  = e_err;
        e.rd   = e_rd;
        e.data = e_data;
        exp_q.push_back(e);
    endtask

    task automatic classic(input logic w, input int word, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c, output logic [31:0] rd);
        int   lat;
        logic is_err;
        is_err = !(c == 3'b000 || c == 3'b111);
        adr    = ($urandom() & ~32'h3FC) | (32'(word) << 2);
        we     = w;
        dat_w  = d;
        sel    = s;
        cti    = c;
        bte    = 2'($urandom());
        cyc    = 1'b1;
        stb    = 1'b1;
        push_exp(is_err, !w, ref_mem[word]);
        if (w && !is_err) ref_mem[word] = merge(ref_mem[word], d, s);
        wait_ack(lat, rd);
        check("classic_latency", 32'(lat), 1);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        check("idle_after_classic", 32'({ack, err}), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int start, input logic [1:0] b, input int n, input logic [7:0] wmask);
        int          word;
        int          lat;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        word = start;
        for (int k = 0; k < n; k++) begin
            d     = $urandom();
            s     = 4'($urandom());
            adr   = ($urandom() & ~32'h3FC) | (32'(word) << 2);
            we    = wmask[k];
            dat_w = d;
            sel   = s;
            cti   = (k == n - 1) ? 3'b111 : 3'b010;
            bte   = b;
            cyc   = 1'b1;
            stb   = 1'b1;
            push_exp(1'b0, !wmask[k], ref_mem[word]);
            if (wmask[k]) ref_mem[word] = merge(ref_mem[word], d, s);
            wait_ack(lat, rd);
            if (k == 0) check("burst_first_latency", 32'(lat), 1);
            else        check("burst_back_to_back", 32'(lat), 0);
            word = next_word(word, b);
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        check("idle_after_burst", 32'({ack, err}), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          p0;
        int          lat;
        int          word;
        int          kind;
        logic [2:0]  ecti;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        #2;
        check("reset_ack", 32'(ack), 0);
        check("reset_err", 32'(err), 0);
        check("reset_ram_we", 32'(ram_we), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Classic write then read back at byte address 0x10.
        classic(1'b1, 4, 32'hDEAD_BEEF, 4'hF, 3'b000, rd);
        classic(1'b0, 4, 32'h0, 4'hF, 3'b000, rd);
        check("t1_readback", rd, 32'hDEAD_BEEF);

        // Byte-lane merge on word 5, one RAM write pulse per write.
        p0 = we_pulses;
        classic(1'b1, 5, 32'h1122_3344, 4'hF, 3'b000, rd);
        check("t2_we_pulses_first", 32'(we_pulses - p0), 1);
        p0 = we_pulses;
        classic(1'b1, 5, 32'h00AA_0000, 4'b0100, 3'b000, rd);
        check("t2_we_pulses_second", 32'(we_pulses - p0), 1);
        classic(1'b0, 5, 32'h0, 4'hF, 3'b000, rd);
        check("t2_readback", rd, 32'h11AA_3344);

        // Linear 4-beat read burst from 0x20, then wrap4 read burst from 0x0C.
        burst(8, 2'b00, 4, 8'h00);
        burst(3, 2'b01, 4, 8'h00);

        // Unsupported cycle type: error response, RAM left untouched.
        p0 = we_pulses;
        classic(1'b1, 4, 32'h1234_5678, 4'hF, 3'b011, rd);
        check("t5_no_ram_write", 32'(we_pulses - p0), 0);
        classic(1'b0, 4, 32'h0, 4'hF, 3'b000, rd);
        check("t5_readback", rd, 32'hDEAD_BEEF);

        // Reset lands while the third beat of a write burst is being acked.
        p0   = we_pulses;
        word = 40;
        for (int k = 0; k < 2; k++) begin
            adr   = 32'(word) << 2;
            we    = 1'b1;
            dat_w = $urandom();
            sel   = 4'hF;
            cti   = 3'b010;
            bte   = 2'b00;
            cyc   = 1'b1;
            stb   = 1'b1;
            push_exp(1'b0, 1'b0, ref_mem[word]);
            ref_mem[word] = dat_w;
            wait_ack(lat, rd);
            check("t6_beat_latency", 32'(lat), (k == 0) ? 1 : 0);
            word = word + 1;
        end
        adr   = 32'(word) << 2;
        dat_w = ~ref_mem[word];
        check("t6_ack_before_reset", 32'(ack), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_ack_cleared", 32'(ack), 0);
        check("t6_ram_we_cleared", 32'(ram_we), 0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_we_pulses", 32'(we_pulses - p0), 2);
        for (int w = 40; w < 43; w++) classic(1'b0, w, 32'h0, 4'hF, 3'b000, rd);

        // Randomised mix of classic, error and burst cycles.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                classic(1'($urandom()), $urandom_range(0, DEPTH - 1), $urandom(),
                        4'($urandom()), (kind[0]) ? 3'b111 : 3'b000, rd);
            end else if (kind == 4) begin
                case ($urandom_range(0, 4))
                    0:       ecti = 3'b001;
                    1:       ecti = 3'b011;
                    2:       ecti = 3'b100;
                    3:       ecti = 3'b101;
                    default: ecti = 3'b110;
                endcase
                classic(1'($urandom()), $urandom_range(0, DEPTH - 1), $urandom(),
                        4'($urandom()), ecti, rd);
            end else begin
                burst($urandom_range(0, DEPTH - 1), 2'($urandom()), $urandom_range(1, 8),
                      8'($urandom()));
            end
        end

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
